// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: run/halt control, next-PC selection
// and a saturating count of RUN cycles for the program-done handshake.
module pc_fetch_unit #(
    parameter int unsigned           PC_W       = 10,
    parameter int unsigned           INSTR_W    = 9,
    parameter int unsigned           OP_W       = 3,
    parameter logic [INSTR_W-1:0]    HALT_INSTR = 9'b111111111,
    parameter int unsigned           CNT_W      = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Branch,
    input  logic [PC_W-1:0]    Target,
    input  logic [INSTR_W-1:0] InstrIn,
    output logic [PC_W-1:0]    PC,
    output logic [INSTR_W-1:0] Instr,
    output logic [OP_W-1:0]    Opcode,
    output logic               Valid,
    output logic               Done,
    output logic [CNT_W-1:0]   CycleCount
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [PC_W-1:0]  PcLast = '1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_halt;
    logic              pc_at_end;

    assign is_halt   = (InstrIn == HALT_INSTR);
    assign pc_at_end = (pc_q == PcLast);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Halt beats branch; a taken branch keeps running even from the last address.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (Start) state_d = StRun;
            StRun: begin
                if (is_halt || (!Branch && pc_at_end)) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        unique case (state_q)
            StIdle: begin
                pc_d = '0;
                if (Start) cnt_d = '0;
            end
            StRun: begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
                if (!is_halt) begin
                    if (Branch) begin
                        pc_d = Target;
                    end else if (!pc_at_end) begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            StDone: begin
                if (Start) begin
                    pc_d  = '0;
                    cnt_d = '0;
                end
            end
            default: begin
                pc_d  = '0;
                cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        Valid      = (state_q == StRun);
        Done       = (state_q == StDone);
        PC         = pc_q;
        CycleCount = cnt_q;
        Instr      = InstrIn;
        Opcode     = InstrIn[INSTR_W-1 -: OP_W];
    end

endmodule
